// File: rtl/moving_average_event_detector.sv
// moving_average_event_detector
//   Debounced, hysteretic threshold-crossing detector for the signed output
//   of the moving-average filter. An episode arms when samples rise above
//   thr_hi_i and ends when they drop below thr_lo_i. Each edge needs DEBOUNCE
//   consecutive qualifying valid samples.
// Ports
//   system1000       clock
//   system1000_rstn  asynchronous reset, active low
//   sample_i         signed averaged sample
//   sample_valid_i   sample_i is valid this cycle
//   thr_hi_i         signed arm threshold (quasi-static)
//   thr_lo_i         signed disarm threshold (quasi-static)
//   clear_i          synchronous clear of state, peak and count
//   rise_o           one-cycle pulse when an episode starts
//   fall_o           one-cycle pulse when an episode ends
//   active_o         high while the episode is HIGH or disarming
//   peak_o           signed maximum sample of the current/last episode
//   event_count_o    saturating number of rise events
//   cfg_err_o        registered flag: thr_lo_i > thr_hi_i
module moving_average_event_detector #(
   parameter int DATA_W   = 8,
   parameter int DEBOUNCE = 4,
   parameter int CNT_W    = 16
) (
   input  logic                     system1000,
   input  logic                     system1000_rstn,
   input  logic signed [DATA_W-1:0] sample_i,
   input  logic                     sample_valid_i,
   input  logic signed [DATA_W-1:0] thr_hi_i,
   input  logic signed [DATA_W-1:0] thr_lo_i,
   input  logic                     clear_i,
   output logic                     rise_o,
   output logic                     fall_o,
   output logic                     active_o,
   output logic signed [DATA_W-1:0] peak_o,
   output logic [CNT_W-1:0]         event_count_o,
   output logic                     cfg_err_o
);

   localparam int RUN_W = $clog2(DEBOUNCE + 1);
   localparam logic [RUN_W-1:0] RUN_DONE = RUN_W'(DEBOUNCE);
   localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);

   localparam logic [1:0] S_LOW    = 2'd0;
   localparam logic [1:0] S_ARM_HI = 2'd1;
   localparam logic [1:0] S_HIGH   = 2'd2;
   localparam logic [1:0] S_ARM_LO = 2'd3;

   localparam logic signed [DATA_W-1:0] PEAK_MIN = {1'b1, {(DATA_W-1){1'b0}}};

   logic [1:0]               state, state_n;
   logic [RUN_W-1:0]         run, run_n, run_inc;
   logic signed [DATA_W-1:0] peak_saved, saved_n, peak_n, peak_max;
   logic                     rise_n, fall_n, hi, lo;
   logic [CNT_W-1:0]         count_n, count_sat;

   always_comb begin
      hi        = sample_i > thr_hi_i;
      lo        = sample_i < thr_lo_i;
      run_inc   = run + 1'b1;
      peak_max  = (sample_i > peak_o) ? sample_i : peak_o;
      count_sat = (event_count_o == '1) ? event_count_o : event_count_o + 1'b1;

      state_n = state;
      run_n   = run;
      peak_n  = peak_o;
      saved_n = peak_saved;
      rise_n  = 1'b0;
      fall_n  = 1'b0;
      count_n = event_count_o;

      if (clear_i) begin
         state_n = S_LOW;
         run_n   = '0;
         peak_n  = PEAK_MIN;
         saved_n = PEAK_MIN;
         count_n = '0;
      end else if (cfg_err_o) begin
         // A forced exit from arming is an aborted episode: undo its peak.
         if (state == S_ARM_HI)
            peak_n = peak_saved;
         state_n = S_LOW;
         run_n   = '0;
      end else if (sample_valid_i) begin
         case (state)
            S_LOW: begin
               if (hi) begin
                  // Remember the last episode's peak in case this one aborts.
                  saved_n = peak_o;
                  peak_n  = sample_i;
                  if (DEBOUNCE == 1) begin
                     state_n = S_HIGH;
                     run_n   = '0;
                     rise_n  = 1'b1;
                     count_n = count_sat;
                  end else begin
                     state_n = S_ARM_HI;
                     run_n   = RUN_ONE;
                  end
               end
            end
            S_ARM_HI: begin
               if (hi) begin
                  peak_n = peak_max;
                  if (run_inc == RUN_DONE) begin
                     state_n = S_HIGH;
                     run_n   = '0;
                     rise_n  = 1'b1;
                     count_n = count_sat;
                  end else begin
                     run_n = run_inc;
                  end
               end else begin
                  state_n = S_LOW;
                  run_n   = '0;
                  peak_n  = peak_saved;
               end
            end
            S_HIGH: begin
               peak_n = peak_max;
               if (lo) begin
                  if (DEBOUNCE == 1) begin
                     state_n = S_LOW;
                     run_n   = '0;
                     fall_n  = 1'b1;
                  end else begin
                     state_n = S_ARM_LO;
                     run_n   = RUN_ONE;
                  end
               end
            end
            S_ARM_LO: begin
               peak_n = peak_max;
               if (lo) begin
                  if (run_inc == RUN_DONE) begin
                     state_n = S_LOW;
                     run_n   = '0;
                     fall_n  = 1'b1;
                  end else begin
                     run_n = run_inc;
                  end
               end else begin
                  state_n = S_HIGH;
                  run_n   = '0;
               end
            end
         endcase
      end
   end

   always_ff @(posedge system1000 or negedge system1000_rstn) begin
      if (!system1000_rstn) begin
         state         <= S_LOW;
         run           <= '0;
         peak_saved    <= PEAK_MIN;
         peak_o        <= PEAK_MIN;
         rise_o        <= 1'b0;
         fall_o        <= 1'b0;
         active_o      <= 1'b0;
         event_count_o <= '0;
         cfg_err_o     <= 1'b0;
      end else begin
         state         <= state_n;
         run           <= run_n;
         peak_saved    <= saved_n;
         peak_o        <= peak_n;
         rise_o        <= rise_n;
         fall_o        <= fall_n;
         active_o      <= (state_n == S_HIGH) || (state_n == S_ARM_LO);
         event_count_o <= count_n;
         cfg_err_o     <= thr_lo_i > thr_hi_i;
      end
   end

endmodule

// File: tb/tb_moving_average_event_detector.sv
module tb_moving_average_event_detector;

   logic              clk = 1'b0;
   logic              rstn;
   logic signed [7:0] sample;
   logic              valid;
   logic signed [7:0] thr_hi;
   logic signed [7:0] thr_lo;
   logic              clear;

   logic              rise_a, fall_a, active_a, cfg_a;
   logic signed [7:0] peak_a;
   logic [15:0]       count_a;
   logic              rise_b, fall_b, active_b, cfg_b;
   logic signed [7:0] peak_b;
   logic [1:0]        count_b;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   moving_average_event_detector #(.DATA_W(8), .DEBOUNCE(4), .CNT_W(16)) u_dut16 (
      .system1000(clk), .system1000_rstn(rstn), .sample_i(sample),
      .sample_valid_i(valid), .thr_hi_i(thr_hi), .thr_lo_i(thr_lo),
      .clear_i(clear), .rise_o(rise_a), .fall_o(fall_a), .active_o(active_a),
      .peak_o(peak_a), .event_count_o(count_a), .cfg_err_o(cfg_a)
   );

   moving_average_event_detector #(.DATA_W(8), .DEBOUNCE(4), .CNT_W(2)) u_dut2 (
      .system1000(clk), .system1000_rstn(rstn), .sample_i(sample),
      .sample_valid_i(valid), .thr_hi_i(thr_hi), .thr_lo_i(thr_lo),
      .clear_i(clear), .rise_o(rise_b), .fall_o(fall_b), .active_o(active_b),
      .peak_o(peak_b), .event_count_o(count_b), .cfg_err_o(cfg_b)
   );

   typedef struct {
      logic v;
      int   s;
      logic r;
      logic f;
      logic a;
      int   pk;
      int   cnt;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic v, input int s, input logic r, input logic f,
                      input logic a, input int pk, input int cnt);
      vec_t e;
      e.v = v; e.s = s; e.r = r; e.f = f; e.a = a; e.pk = pk; e.cnt = cnt;
      tbl.push_back(e);
   endtask

   task automatic chk(input string nm, input logic signed [31:0] act,
                      input logic signed [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic step(input logic v, input int s);
      valid  = v;
      sample = 8'(s);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rstn = 1'b0; sample = '0; valid = 1'b0; clear = 1'b0;
      thr_hi = 8'sd20; thr_lo = 8'sd5;

      // From reset: aborted arm, full rise, debounced fall with gaps,
      // abort restoring the previous peak, equal-threshold samples,
      // peak tracking in HIGH, disarm cancel resetting the run.
      add(1, 25, 0,0,0,   25, 0);
      add(1, 30, 0,0,0,   30, 0);
      add(1, 10, 0,0,0, -128, 0);
      add(1, 25, 0,0,0,   25, 0);
      add(1, 30, 0,0,0,   30, 0);
      add(0,  0, 0,0,0,   30, 0);
      add(1, 22, 0,0,0,   30, 0);
      add(1, 40, 1,0,1,   40, 1);
      add(0,  0, 0,0,1,   40, 1);
      add(1,  3, 0,0,1,   40, 1);
      add(0,  0, 0,0,1,   40, 1);
      add(1,  2, 0,0,1,   40, 1);
      add(0,  0, 0,0,1,   40, 1);
      add(1,  1, 0,0,1,   40, 1);
      add(0,  0, 0,0,1,   40, 1);
      add(1,  0, 0,1,0,   40, 1);
      add(0,  0, 0,0,0,   40, 1);
      add(1, 25, 0,0,0,   25, 1);
      add(1, 30, 0,0,0,   30, 1);
      add(1, 10, 0,0,0,   40, 1);
      for (int i = 0; i < 8; i++) add(1, 20, 0,0,0, 40, 1);
      for (int i = 0; i < 3; i++) add(1, 21, 0,0,0, 21, 1);
      add(1, 21, 1,0,1,   21, 2);
      add(1, 35, 0,0,1,   35, 2);
      for (int i = 0; i < 4; i++) add(1, 5, 0,0,1, 35, 2);
      add(1,  6, 0,0,1,   35, 2);
      add(1,  4, 0,0,1,   35, 2);
      add(1, 10, 0,0,1,   35, 2);
      for (int i = 0; i < 3; i++) add(1, 4, 0,0,1, 35, 2);
      add(1,  4, 0,1,0,   35, 2);
      add(1,  4, 0,0,0,   35, 2);

      #12;
      chk("reset_rise",   rise_a,   0);
      chk("reset_fall",   fall_a,   0);
      chk("reset_active", active_a, 0);
      chk("reset_peak",   peak_a, -128);
      chk("reset_count",  count_a,  0);
      chk("reset_cfg",    cfg_a,    0);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;

      foreach (tbl[i]) begin
         step(tbl[i].v, tbl[i].s);
         chk($sformatf("vec%0d_rise",   i), rise_a,   tbl[i].r);
         chk($sformatf("vec%0d_fall",   i), fall_a,   tbl[i].f);
         chk($sformatf("vec%0d_active", i), active_a, tbl[i].a);
         chk($sformatf("vec%0d_peak",   i), peak_a,   tbl[i].pk);
         chk($sformatf("vec%0d_count",  i), count_a,  tbl[i].cnt);
      end

      // Inverted thresholds block arming.
      thr_lo = 8'sd30;
      step(0, 0);
      chk("cfg_err_set", cfg_a, 1);
      for (int i = 0; i < 6; i++) begin
         step(1, 50);
         chk($sformatf("cfg_rise%0d", i), rise_a, 0);
         chk($sformatf("cfg_active%0d", i), active_a, 0);
      end
      chk("cfg_count_hold", count_a, 2);
      thr_lo = 8'sd5;
      step(0, 0);
      chk("cfg_err_clr", cfg_a, 0);

      // Inverted thresholds force an active episode down without a fall.
      for (int i = 0; i < 4; i++) begin
         step(1, 50);
         chk($sformatf("pre_force_rise%0d", i), rise_a, (i == 3) ? 1 : 0);
      end
      chk("pre_force_count", count_a, 3);
      thr_lo = 8'sd30;
      step(0, 0);
      chk("force_cfg", cfg_a, 1);
      chk("force_active_still", active_a, 1);
      step(0, 0);
      chk("force_active_drop", active_a, 0);
      chk("force_no_fall", fall_a, 0);
      thr_lo = 8'sd5;
      step(0, 0);

      // Clear wins over a same-cycle valid sample.
      clear = 1'b1;
      step(1, 50);
      clear = 1'b0;
      chk("clear_count16", count_a, 0);
      chk("clear_count2",  count_b, 0);
      chk("clear_peak",    peak_a, -128);
      chk("clear_active",  active_a, 0);

      // Saturation of the 2-bit counter over five episodes.
      for (int k = 1; k <= 5; k++) begin
         for (int i = 0; i < 4; i++) begin
            step(1, 50);
            chk($sformatf("ep%0d_rise%0d", k, i), rise_b, (i == 3) ? 1 : 0);
         end
         chk($sformatf("ep%0d_count2", k), count_b, (k > 3) ? 3 : k);
         chk($sformatf("ep%0d_count16", k), count_a, k);
         for (int i = 0; i < 4; i++) begin
            step(1, 0);
            chk($sformatf("ep%0d_fall%0d", k, i), fall_b, (i == 3) ? 1 : 0);
         end
      end

      // Reset asserted while arming.
      step(1, 50);
      step(1, 50);
      chk("arm_peak", peak_a, 50);
      #1 rstn = 1'b0;
      #1;
      chk("mid_rst_peak",   peak_a, -128);
      chk("mid_rst_count",  count_a, 0);
      chk("mid_rst_count2", count_b, 0);
      chk("mid_rst_active", active_a, 0);
      chk("mid_rst_rise",   rise_a, 0);
      @(posedge clk);
      #1;
      chk("mid_rst_held_peak", peak_a, -128);
      rstn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(1, 50);
         chk($sformatf("post_rst_rise%0d", i), rise_a, (i == 3) ? 1 : 0);
      end
      chk("post_rst_count", count_a, 1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
